// File: rtl/ddr_rd_streamer_pkg.sv
// ddr_rd_pkg: types and AXI constants used by the DDR read streamer.
//   state_t    : streamer control states
//   BURST_INCR : AXI INCR burst type encoding
//   RESP_OKAY  : AXI OKAY response encoding
//   axi_size() : AxSIZE encoding for a data width given in bits
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int b);
        return 3'($clog2(b / 8));
    endfunction

endpackage

// File: rtl/ddr_rd_streamer_if.sv
// ddr_rd_streamer_if: AXI4 read-address/read-data channels plus the
// AXI4-Stream output of the DDR read streamer.
//   master modport : the streamer (drives AR, rready, stream)
//   slave  modport : the DDR interconnect / MAC side
interface ddr_rd_streamer_if #(
    parameter int B      = 64,
    parameter int ADDR_W = 40
);
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;

    logic [B-1:0]      m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    logic [B-1:0]      m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/ddr_rd_streamer_axis_skid.sv
// axis_skid: 2-entry register skid buffer carrying B data bits plus tlast.
// in_ready is a flop (not full after this cycle), so the upstream ready path
// never sees the downstream tready combinationally.
//   clk, rstn                  : clock, async active-low reset
//   in_data/in_last/in_valid   : upstream beat, in_ready back
//   out_data/out_last/out_valid: downstream beat, out_ready in
module axis_skid #(
    parameter int B = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [B-1:0] in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [B-1:0] out_data,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [B:0] mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_next;
    logic       push, pop;

    assign push      = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr][B-1:0];
    assign out_last  = out_valid && mem[rd_ptr][B];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_last, in_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
        end
    end
endmodule

// File: rtl/ddr_rd_streamer.sv
// ddr_rd_streamer: AXI4 read master fetching a contiguous DDR region in
// fixed-length INCR bursts, streaming the returned beats to the MAC.
//   clk, rstn                 : clock, async active-low reset
//   start/addr_base/len_beats : transfer request (sampled in IDLE)
//   busy/done/err             : status; err is sticky until next start
//   stat_cycles/beats/stalls  : counters, built only with DDR_RD_STATS_EN
//   bus                       : AXI AR/R master and AXI-Stream master
module ddr_rd_streamer
    import ddr_rd_pkg::*;
#(
    parameter int B               = 64,
    parameter int ADDR_W          = 40,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic [31:0]       len_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       stat_cycles,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_stalls,
    ddr_rd_streamer_if.master bus
);
    localparam int                OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * B / 8);
    localparam logic [OUT_W-1:0]  OUT_MAX     = OUT_W'(MAX_OUTSTANDING);

    state_t            state, state_next;
    logic [31:0]       len_q, rem_q, rem_eff, r_cnt;
    logic [OUT_W-1:0]  outstanding, out_next;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic              accept, active, ar_hs, r_hs, t_hs, skid_ready;

    function automatic logic [7:0] burst_arlen(input logic [31:0] rem);
        return (rem >= 32'(BURST_LEN)) ? 8'(BURST_LEN - 1) : 8'(rem - 32'd1);
    endfunction

    assign accept  = (state == ST_IDLE) && start;
    assign active  = (state == ST_ADDR) || (state == ST_DRAIN);
    assign ar_hs   = arvalid_q && bus.m_axi_arready;
    assign r_hs    = bus.m_axi_rvalid && bus.m_axi_rready;
    assign t_hs    = bus.m_axis_tvalid && bus.m_axis_tready;
    // Beats still to be requested once this cycle's AR handshake is counted.
    assign rem_eff = ar_hs ? (rem_q - (32'(arlen_q) + 32'd1)) : rem_q;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = axi_size(B);
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = skid_ready && active;

    always_comb begin
        out_next = outstanding;
        if (ar_hs && !(r_hs && bus.m_axi_rlast))
            out_next = outstanding + OUT_W'(1);
        else if (!ar_hs && r_hs && bus.m_axi_rlast)
            out_next = outstanding - OUT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (len_beats == 32'd0) ? ST_DONE : ST_ADDR;
            ST_ADDR:  if (ar_hs && rem_eff == 32'd0) state_next = ST_DRAIN;
            ST_DRAIN: if (t_hs && bus.m_axis_tlast) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q       <= '0;
            rem_q       <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            err         <= 1'b0;
        end else if (accept) begin
            len_q       <= len_beats;
            rem_q       <= len_beats;
            r_cnt       <= '0;
            outstanding <= '0;
            araddr_q    <= addr_base;
            err         <= 1'b0;
            arvalid_q   <= (len_beats != 32'd0);
            if (len_beats != 32'd0) arlen_q <= burst_arlen(len_beats);
        end else begin
            outstanding <= out_next;
            if (r_hs) begin
                r_cnt <= r_cnt + 32'd1;
                if (bus.m_axi_rresp != RESP_OKAY) err <= 1'b1;
            end
            if (ar_hs) begin
                araddr_q <= araddr_q + BURST_BYTES;
                rem_q    <= rem_eff;
            end
            // Payload only changes while no request is pending on the bus.
            if (ar_hs || !arvalid_q) begin
                arvalid_q <= (state == ST_ADDR) && (rem_eff != 32'd0) && (out_next < OUT_MAX);
                if (rem_eff != 32'd0) arlen_q <= burst_arlen(rem_eff);
            end
        end
    end

    axis_skid #(.B(B)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (bus.m_axi_rdata),
        .in_last   ((r_cnt + 32'd1) == len_q),
        .in_valid  (bus.m_axi_rvalid && active),
        .in_ready  (skid_ready),
        .out_data  (bus.m_axis_tdata),
        .out_last  (bus.m_axis_tlast),
        .out_valid (bus.m_axis_tvalid),
        .out_ready (bus.m_axis_tready)
    );

`ifdef DDR_RD_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_cycles <= '0;
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if (accept) begin
            stat_cycles <= 32'd1;
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if (busy) begin
            if (stat_cycles != '1) stat_cycles <= stat_cycles + 32'd1;
            if (t_hs && stat_beats != '1) stat_beats <= stat_beats + 32'd1;
            if (bus.m_axis_tvalid && !bus.m_axis_tready && stat_stalls != '1)
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`else
    assign stat_cycles = '0;
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_ddr_rd_streamer.sv
// Self-checking bench for ddr_rd_streamer: a DDR slave model whose memory word
// is a fixed function of the byte address, a randomized stream sink, and a
// reference model of the expected AR list and beat sequence.
module tb_ddr_rd_streamer;
    localparam int B = 64, ADDR_W = 40, BL = 16, MAXO = 4, BYTES = B / 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] addr_base = '0;
    logic [31:0]       len_beats = '0;
    logic              busy, done, err;
    logic [31:0]       stat_cycles, stat_beats, stat_stalls;

    ddr_rd_streamer_if #(.B(B), .ADDR_W(ADDR_W)) bus ();

    ddr_rd_streamer #(.B(B), .ADDR_W(ADDR_W), .BURST_LEN(BL), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .addr_base(addr_base), .len_beats(len_beats),
        .busy(busy), .done(done), .err(err),
        .stat_cycles(stat_cycles), .stat_beats(stat_beats), .stat_stalls(stat_stalls),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int tready_pct = 100, r_pct = 100, ar_pct = 100, hold_cnt = 0, err_beat = 0;

    logic [B:0]        rbeat_q[$];
    logic [ADDR_W-1:0] ar_addr_log[$];
    logic [7:0]        ar_len_log[$];
    logic [B-1:0]      out_data_q[$];
    logic              out_last_q[$];
    int cyc = 0, r_idx = 0, n_ar = 0, n_rlast = 0, max_out = 0, ar_bad = 0;
    int arv_seen = 0, done_cnt = 0, stalls_obs = 0, first_rlast_cyc = -1, ar_before_rlast = 0;
    int ar5_cyc = -1;
    bit r_accepted = 0, ar_wait = 0;
    logic [ADDR_W-1:0] p_addr;
    logic [7:0]        p_len;

    function automatic logic [B-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[31:0] ^ 32'hA5C3_0F1E, 24'h5A5A5A, a[39:32]};
    endfunction

    // Handshake monitor: records what crossed each channel at the clock edge.
    always @(posedge clk) begin
        cyc++;
        if (rstn) begin
            if (bus.m_axi_arvalid) arv_seen++;
            if (ar_wait && (!bus.m_axi_arvalid || bus.m_axi_araddr !== p_addr || bus.m_axi_arlen !== p_len))
                ar_bad++;
            ar_wait = bus.m_axi_arvalid && !bus.m_axi_arready;
            p_addr  = bus.m_axi_araddr;
            p_len   = bus.m_axi_arlen;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_addr_log.push_back(bus.m_axi_araddr);
                ar_len_log.push_back(bus.m_axi_arlen);
                if (bus.m_axi_arsize !== 3'd3 || bus.m_axi_arburst !== 2'b01) ar_bad++;
                for (int j = 0; j <= int'(bus.m_axi_arlen); j++)
                    rbeat_q.push_back({(j == int'(bus.m_axi_arlen)),
                                       mem_word(bus.m_axi_araddr + ADDR_W'(j * BYTES))});
                n_ar++;
                if (n_ar == 5) ar5_cyc = cyc;
                if (first_rlast_cyc < 0) ar_before_rlast++;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                void'(rbeat_q.pop_front());
                r_idx++;
                r_accepted = 1;
                if (bus.m_axi_rlast) begin
                    n_rlast++;
                    if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
                end
            end
            if (n_ar - n_rlast > max_out) max_out = n_ar - n_rlast;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                out_data_q.push_back(bus.m_axis_tdata);
                out_last_q.push_back(bus.m_axis_tlast);
            end
            if (bus.m_axis_tvalid && !bus.m_axis_tready) stalls_obs++;
            if (done) done_cnt++;
        end
    end

    // Slave and sink drivers, updated away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            bus.m_axi_arready = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            bus.m_axis_tready = 1'b0;
            r_accepted = 0;
        end else begin
            bus.m_axi_arready = ($urandom_range(99) < ar_pct);
            bus.m_axis_tready = ($urandom_range(99) < tready_pct);
            if (hold_cnt > 0) hold_cnt--;
            if (!bus.m_axi_rvalid || r_accepted) begin
                if (rbeat_q.size() > 0 && hold_cnt == 0 && $urandom_range(99) < r_pct) begin
                    bus.m_axi_rvalid = 1'b1;
                    {bus.m_axi_rlast, bus.m_axi_rdata} = rbeat_q[0];
                    bus.m_axi_rresp = (r_idx + 1 == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                end
            end
            r_accepted = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rbeat_q.delete(); ar_addr_log.delete(); ar_len_log.delete();
        out_data_q.delete(); out_last_q.delete();
        r_idx = 0; n_ar = 0; n_rlast = 0; max_out = 0; ar_bad = 0; arv_seen = 0;
        done_cnt = 0; stalls_obs = 0; first_rlast_cyc = -1; ar_before_rlast = 0;
        ar5_cyc = -1; ar_wait = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, {busy, done, err, bus.m_axi_arvalid, bus.m_axi_rready,
                             bus.m_axis_tvalid, bus.m_axis_tlast}, 0);
        chk({tag, "_araddr"}, bus.m_axi_araddr, 0);
        chk({tag, "_arlen"}, bus.m_axi_arlen, 0);
        chk({tag, "_stats"}, stat_cycles | stat_beats | stat_stalls, 0);
    endtask

    task automatic run_xfer(input logic [ADDR_W-1:0] base, input int len);
        int t, n_bursts, bad, last_bad;
        bit exp_err;
        clear_logs();
        exp_err = (err_beat >= 1) && (err_beat <= len);
        @(negedge clk);
        start = 1'b1; addr_base = base; len_beats = len;
        @(negedge clk);
        start = 1'b0;
        chk("busy_c1", busy, 1);
        chk("arvalid_c1", bus.m_axi_arvalid, (len != 0));
        chk("err_cleared", err, 0);
        if (len == 0) chk("done_c1", done, 1);
        t = 0;
        while (!done && t < 4000) begin @(negedge clk); t++; end
        chk("done_seen", done, 1);
        if (done) begin
            chk("busy_at_done", busy, 1);
            chk("err_at_done", err, exp_err);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
        end
        repeat (3) @(negedge clk);
        n_bursts = (len + BL - 1) / BL;
        chk("ar_count", ar_addr_log.size(), n_bursts);
        bad = 0;
        for (int k = 0; k < n_bursts && k < ar_addr_log.size(); k++) begin
            if (ar_addr_log[k] !== base + ADDR_W'(k * BL * BYTES)) bad++;
            if (int'(ar_len_log[k]) != ((len - k * BL >= BL) ? BL : len - k * BL) - 1) bad++;
        end
        chk("ar_payload", bad, 0);
        chk("ar_protocol", ar_bad, 0);
        chk("outstanding_le_max", (max_out <= MAXO), 1);
        chk("beat_count", out_data_q.size(), len);
        bad = 0; last_bad = 0;
        for (int i = 0; i < out_data_q.size(); i++) begin
            if (out_data_q[i] !== mem_word(base + ADDR_W'(i * BYTES))) bad++;
            if (out_last_q[i] !== (i == len - 1)) last_bad++;
        end
        chk("stream_data", bad, 0);
        chk("tlast_position", last_bad, 0);
        chk("done_pulses", done_cnt, 1);
        if (len == 0) chk("no_arvalid", arv_seen, 0);
`ifdef DDR_RD_STATS_EN
        chk("stat_beats", stat_beats, len);
        chk("stat_stalls", stat_stalls, stalls_obs);
`else
        chk("stats_tied_off", stat_cycles | stat_beats | stat_stalls, 0);
`endif
    endtask

    function automatic logic [ADDR_W-1:0] rand_base();
        return {8'($urandom_range(255)), 32'($urandom)} & ~ADDR_W'(BL * BYTES - 1);
    endfunction

    initial begin
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axis_tready = 1'b0;
        #1;
        check_reset("por");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_xfer(40'h00_1000_0000, 32);
        run_xfer(40'h00_2000_0080, 20);
        run_xfer(40'h00_3000_0000, 0);

        tready_pct = 50; r_pct = 50; ar_pct = 50;
        run_xfer(rand_base(), 77);
        for (int n = 0; n < 3; n++) begin
            tready_pct = $urandom_range(30, 100);
            r_pct      = $urandom_range(30, 100);
            ar_pct     = $urandom_range(30, 100);
            run_xfer(rand_base(), $urandom_range(1, 100));
        end

        tready_pct = 100; r_pct = 100; ar_pct = 100;
        hold_cnt = 200;
        run_xfer(40'h00_4000_0000, 128);
        chk("ars_before_first_rlast", ar_before_rlast, MAXO);
        chk("max_outstanding", max_out, MAXO);
        chk("ar5_after_rlast", (ar5_cyc > first_rlast_cyc) && (ar5_cyc <= first_rlast_cyc + 2), 1);

        tready_pct = 70; err_beat = 5;
        run_xfer(rand_base(), 40);
        err_beat = 0;
        run_xfer(rand_base(), 24);

        tready_pct = 60; r_pct = 70; err_beat = 3;
        clear_logs();
        @(negedge clk);
        start = 1'b1; addr_base = 40'h00_5000_0000; len_beats = 200;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("err_before_reset", err, 1);
        rstn = 1'b0;
        #1;
        check_reset("mid_rst");
        clear_logs();
        err_beat = 0; hold_cnt = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_xfer(40'h00_6000_0000, 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
